// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM peripheral: decoder states, command-byte
// field positions and the register map used by both decoder and register file.
package pwm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT,
        RD_CAPTURE,
        RD_DUMMY
    } state_t;

    localparam int CMD_WR_BIT = 7;
    localparam int ADDR_MSB   = 5;

    localparam logic [ADDR_MSB:0] PERIOD_L  = 6'h00;
    localparam logic [ADDR_MSB:0] PERIOD_H  = 6'h01;
    localparam logic [ADDR_MSB:0] DUTY0_L   = 6'h02;
    localparam logic [ADDR_MSB:0] DUTY0_H   = 6'h03;
    localparam logic [ADDR_MSB:0] DUTY1_L   = 6'h04;
    localparam logic [ADDR_MSB:0] DUTY1_H   = 6'h05;
    localparam logic [ADDR_MSB:0] DUTY2_L   = 6'h06;
    localparam logic [ADDR_MSB:0] DUTY2_H   = 6'h07;
    localparam logic [ADDR_MSB:0] DUTY3_L   = 6'h08;
    localparam logic [ADDR_MSB:0] DUTY3_H   = 6'h09;
    localparam logic [ADDR_MSB:0] PRESCALE  = 6'h0A;
    localparam logic [ADDR_MSB:0] CONTROL   = 6'h0B;
    localparam logic [ADDR_MSB:0] STATUS    = 6'h0C;
    localparam logic [ADDR_MSB:0] FUNCTIONS = 6'h0D;

    // States in which the decoder waits on the SPI master and may time out.
    function automatic logic is_waiting(state_t s);
        return (s == WR_DATA) || (s == RD_DUMMY);
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Register-file access bus: the decoder is the master, the register file the slave.
interface spi_cmd_decoder_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] data_read;

    modport master (output read, output write, output addr, output data_write, input data_read);
    modport slave  (input read, input write, input addr, input data_write, output data_read);
endinterface

// File: rtl/spi_cmd_decoder_timeout.sv
// Idle-cycle counter for the decoder's wait states; expire fires on the cycle
// in which the count would reach TIMEOUT. TIMEOUT of 0 disables it.
module cmd_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic expire
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expire = (TIMEOUT != 0) && enable && !load && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/spi_cmd_decoder.sv
// Turns each 2-byte SPI frame into one register-file read or write and
// returns read data to the SPI bridge for shifting out.
module spi_cmd_decoder
    import pwm_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_active,
    input  logic [DATA_W-1:0] rx_byte,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] tx_byte,
    output logic              tx_load,
    output logic              busy,
    output logic              proto_err,
    spi_cmd_decoder_if.master reg_bus
);
    state_t state;
    logic   take;
    logic   waiting;
    logic   expire;

    assign take    = rx_valid && frame_active;
    assign waiting = is_waiting(state);

    // Held clear outside the wait states, so every entry starts from zero.
    cmd_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (~waiting),
        .enable (waiting),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            tx_byte            <= '0;
            tx_load            <= 1'b0;
            busy               <= 1'b0;
            proto_err          <= 1'b0;
            reg_bus.read       <= 1'b0;
            reg_bus.write      <= 1'b0;
            reg_bus.addr       <= '0;
            reg_bus.data_write <= '0;
        end else begin
            // NOTE: non-blocking throughout, and the strobes default low here so each
            // case branch only has to raise the one pulse it owns for a single cycle.
            reg_bus.read  <= 1'b0;
            reg_bus.write <= 1'b0;
            tx_load       <= 1'b0;
            proto_err     <= 1'b0;

            case (state)
                IDLE: begin
                    if (take) begin
                        reg_bus.addr <= rx_byte[ADDR_W-1:0];
                        busy         <= 1'b1;
                        if (rx_byte[CMD_WR_BIT]) begin
                            state <= WR_DATA;
                        end else begin
                            state        <= RD_ISSUE;
                            reg_bus.read <= 1'b1;
                        end
                    end
                end

                WR_DATA: begin
                    if (!frame_active) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        proto_err <= 1'b1;
                    end else if (rx_valid) begin
                        reg_bus.data_write <= rx_byte;
                        reg_bus.write      <= 1'b1;
                        state              <= WR_ISSUE;
                    end else if (expire) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        proto_err <= 1'b1;
                    end
                end

                WR_ISSUE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    proto_err <= take;
                end

                RD_ISSUE: begin
                    if (!frame_active) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state     <= RD_WAIT;
                        proto_err <= rx_valid;
                    end
                end

                RD_WAIT: begin
                    if (!frame_active) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        tx_byte   <= reg_bus.data_read;
                        tx_load   <= 1'b1;
                        state     <= RD_CAPTURE;
                        proto_err <= rx_valid;
                    end
                end

                RD_CAPTURE: begin
                    if (!frame_active) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state     <= RD_DUMMY;
                        proto_err <= rx_valid;
                    end
                end

                RD_DUMMY: begin
                    // A dropped chip select here is the normal end of a read frame.
                    if (!frame_active || rx_valid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (expire) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        proto_err <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: each scenario queues the strobes it
// expects (kind, cycle, value) and a monitor pops them as the DUT emits them.
module tb_spi_cmd_decoder;
    import pwm_pkg::*;

    typedef enum int {EV_RD = 0, EV_WR = 1, EV_TX = 2, EV_ERR = 3} ev_kind_t;

    typedef struct {
        ev_kind_t   kind;
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b0;
    logic       frame_active = 1'b0;
    logic       rx_valid     = 1'b0;
    logic [7:0] rx_byte      = 8'h00;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic       busy;
    logic       proto_err;

    int  cyc      = 0;
    int  checks   = 0;
    int  failures = 0;
    ev_t exp_q[$];

    logic [7:0] mem [64];

    spi_cmd_decoder_if #(.ADDR_W(6), .DATA_W(8)) reg_bus ();

    spi_cmd_decoder #(.ADDR_W(6), .DATA_W(8), .TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_active (frame_active),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .tx_byte      (tx_byte),
        .tx_load      (tx_load),
        .busy         (busy),
        .proto_err    (proto_err),
        .reg_bus      (reg_bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register-file model: registered read data, contents start as addr ^ 0x56.
    always @(posedge clk) begin
        if (!rst_n) begin
            reg_bus.data_read <= 8'h00;
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i) ^ 8'h56;
        end else begin
            if (reg_bus.read) reg_bus.data_read <= mem[reg_bus.addr];
            if (reg_bus.write) mem[reg_bus.addr] <= reg_bus.data_write;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic push(input ev_kind_t k, input int c, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        frame_active = 1'b0;
        tick(3);
        @(negedge clk);
        checks++;
        if ({tx_byte, tx_load, reg_bus.read, reg_bus.write, reg_bus.addr,
             reg_bus.data_write, busy, proto_err} !== 27'd0) begin
            failures++;
            $display("FAIL reset_values got tx=%h ld=%b rd=%b wr=%b addr=%h dw=%h busy=%b err=%b want all zero",
                     tx_byte, tx_load, reg_bus.read, reg_bus.write, reg_bus.addr,
                     reg_bus.data_write, busy, proto_err);
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_write();
        int c;
        frame_active = 1'b1;
        tick(1);
        c = cyc;
        push(EV_WR, c + 2, 8'h00, 8'h34);
        send_byte(8'h80);
        send_byte(8'h34);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL write_busy_issue got=%b want=1", busy);
        end
        tick(1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL write_busy_fall got=%b want=0", busy);
        end
        frame_active = 1'b0;
        tick(1);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL write_pending got=%0d want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_read();
        int c;
        frame_active = 1'b1;
        tick(1);
        c = cyc;
        push(EV_RD, c + 1, 8'h0A, 8'h00);
        push(EV_TX, c + 3, 8'h00, 8'h5C);
        send_byte(8'h0A);
        tick(3);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL read_busy_dummy got=%b want=1", busy);
        end
        send_byte(8'hFF);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL read_idle got=%b want=0", busy);
        end
        checks++;
        if (reg_bus.addr !== 6'h0A) begin
            failures++;
            $display("FAIL read_addr_hold got=%h want=0a", reg_bus.addr);
        end
        frame_active = 1'b0;
        tick(1);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL read_pending got=%0d want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_abort();
        int c;
        frame_active = 1'b1;
        tick(1);
        c = cyc;
        push(EV_ERR, c + 2, 8'h00, 8'h00);
        send_byte(8'h83);
        frame_active = 1'b0;
        tick(1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got=%b want=0", busy);
        end
        checks++;
        if (reg_bus.addr !== 6'h03) begin
            failures++;
            $display("FAIL abort_addr got=%h want=03", reg_bus.addr);
        end
        tick(3);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL abort_pending got=%0d want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_timeout();
        int c;
        frame_active = 1'b1;
        tick(1);
        c = cyc;
        push(EV_ERR, c + 5, 8'h00, 8'h00);
        send_byte(8'h81);
        tick(3);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_wait got=%b want=1", busy);
        end
        tick(1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle got=%b want=0", busy);
        end
        tick(3);
        frame_active = 1'b0;
        tick(1);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL timeout_pending got=%0d want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_overrun();
        int c;
        frame_active = 1'b1;
        tick(1);
        c = cyc;
        push(EV_RD, c + 1, 8'h07, 8'h00);
        push(EV_TX, c + 3, 8'h00, 8'h51);
        push(EV_ERR, c + 3, 8'h00, 8'h00);
        send_byte(8'h07);
        tick(1);
        send_byte(8'h11);
        tick(1);
        send_byte(8'hEE);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL overrun_idle got=%b want=0", busy);
        end
        frame_active = 1'b0;
        tick(1);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL overrun_pending got=%0d want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int c;
        frame_active = 1'b1;
        tick(1);
        c = cyc;
        push(EV_WR, c + 2, 8'h05, 8'h99);
        push(EV_RD, c + 4, 8'h05, 8'h00);
        push(EV_TX, c + 6, 8'h00, 8'h99);
        send_byte(8'h85);
        send_byte(8'h99);
        tick(1);
        send_byte(8'h05);
        tick(3);
        send_byte(8'hFF);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle got=%b want=0", busy);
        end
        frame_active = 1'b0;
        tick(1);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_pending got=%0d want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int c;
        frame_active = 1'b1;
        tick(1);
        c = cyc;
        push(EV_RD, c + 1, 8'h0C, 8'h00);
        send_byte(8'h0C);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (reg_bus.read !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_read got=%b want=0", reg_bus.read);
        end
        checks++;
        if ({tx_byte, tx_load, reg_bus.read, reg_bus.write, reg_bus.addr,
             reg_bus.data_write, busy, proto_err} !== 27'd0) begin
            failures++;
            $display("FAIL rst_mid_values got tx=%h ld=%b rd=%b wr=%b addr=%h dw=%h busy=%b err=%b want all zero",
                     tx_byte, tx_load, reg_bus.read, reg_bus.write, reg_bus.addr,
                     reg_bus.data_write, busy, proto_err);
        end
        frame_active = 1'b0;
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        frame_active = 1'b1;
        c = cyc;
        push(EV_RD, c + 1, 8'h0C, 8'h00);
        push(EV_TX, c + 3, 8'h00, 8'h5A);
        send_byte(8'h0C);
        tick(3);
        send_byte(8'hFF);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_recover got=%b want=0", busy);
        end
        frame_active = 1'b0;
        tick(1);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rst_mid_pending got=%0d want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        fork
            begin : sb_monitor
                ev_t        e;
                logic       hit;
                logic [7:0] a;
                logic [7:0] d;
                forever begin
                    @(negedge clk);
                    if (rst_n) begin
                        checks++;
                        if ((reg_bus.read && reg_bus.write) !== 1'b0) begin
                            failures++;
                            $display("FAIL rd_wr_overlap cyc=%0d rd=%b wr=%b want not both",
                                     cyc, reg_bus.read, reg_bus.write);
                        end
                        for (int k = 0; k < 4; k++) begin
                            hit = 1'b0;
                            a   = 8'h00;
                            d   = 8'h00;
                            case (k)
                                0: begin hit = reg_bus.read;  a = {2'b00, reg_bus.addr}; end
                                1: begin hit = reg_bus.write; a = {2'b00, reg_bus.addr}; d = reg_bus.data_write; end
                                2: begin hit = tx_load; d = tx_byte; end
                                default: hit = proto_err;
                            endcase
                            if (hit === 1'b1) begin
                                checks++;
                                if (exp_q.size() == 0) begin
                                    failures++;
                                    $display("FAIL sb_unexpected kind=%0d cyc=%0d addr=%h data=%h want no event",
                                             k, cyc, a, d);
                                end else begin
                                    e = exp_q.pop_front();
                                    if (e.kind != ev_kind_t'(k) || e.cyc != cyc ||
                                        e.addr !== a || e.data !== d) begin
                                        failures++;
                                        $display("FAIL sb_event got kind=%0d cyc=%0d addr=%h data=%h want kind=%0d cyc=%0d addr=%h data=%h",
                                                 k, cyc, a, d, int'(e.kind), e.cyc, e.addr, e.data);
                                    end
                                end
                            end
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_write();
        test_read();
        test_abort();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
